// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch stage behind a one-cycle-latency IRAM.
//             Drives the IRAM word address, assembles one-word (opcode) and
//             two-word (opcode + operand) instructions, and presents them to
//             the control unit over a valid/ready handshake. It also handles
//             jump redirects taken at the handshake and halts on ENDOP.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC       fetch start address, loaded on reset and on start
//  Ports
//    clk            system clock, rising edge
//    rst            asynchronous active-high reset
//    start          begin fetching at RESET_PC (honoured in IDLE / HALT)
//    iram_addr      registered IRAM word address
//    iram_data      IRAM read data, valid one cycle after iram_addr
//    instr_valid    instruction fields valid, held until accepted
//    instr_ready    control unit accepts the instruction
//    instr_opcode   opcode word
//    instr_operand  operand word (0 for one-word instructions)
//    instr_has_arg  instruction is two words
//    instr_pc       address of the opcode word
//    branch_en      redirect request, sampled only on the handshake
//    branch_target  redirect address
//    busy           high in every state except IDLE and HALT
//    halted         high in HALT
//    instr_illegal  sticky illegal-opcode flag
//  Configuration macro
//    IFETCH_OPCHECK_EN  when defined, illegal opcodes halt the fetch and set
//                       instr_illegal; otherwise they are treated as one-word
// ============================================================================
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [15:0] iram_addr,
   input  logic [15:0] iram_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr_opcode,
   output logic [15:0] instr_operand,
   output logic        instr_has_arg,
   output logic [15:0] instr_pc,
   input  logic        branch_en,
   input  logic [15:0] branch_target,
   output logic        busy,
   output logic        halted,
   output logic        instr_illegal
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_OP_ADDR  = 3'd1;
   localparam logic [2:0] S_OP_DATA  = 3'd2;
   localparam logic [2:0] S_ARG_ADDR = 3'd3;
   localparam logic [2:0] S_ARG_DATA = 3'd4;
   localparam logic [2:0] S_VALID    = 3'd5;
   localparam logic [2:0] S_HALT     = 3'd6;

   localparam logic [15:0] OP_ENDOP  = 16'd51;

   logic [2:0]  state;
   logic [15:0] pc;
   logic [15:0] next_pc;
   logic        fetched_two_word;
   logic        fetched_illegal;

   function automatic logic is_two_word(input logic [15:0] op);
      return op inside {16'd5, 16'd7, 16'd9, 16'd14, 16'd19, 16'd24,
                        16'd46, 16'd48};
   endfunction

`ifdef IFETCH_OPCHECK_EN
   function automatic logic is_legal(input logic [15:0] op);
      return op inside {16'd5, 16'd7, 16'd9, 16'd14, 16'd19, 16'd24,
                        [16'd29:16'd36], 16'd38, 16'd40, 16'd42, 16'd44,
                        16'd46, 16'd48, [16'd50:16'd55], 16'd59};
   endfunction
`endif

   always_comb begin
      fetched_two_word = is_two_word(iram_data);
`ifdef IFETCH_OPCHECK_EN
      fetched_illegal  = !is_legal(iram_data);
`else
      fetched_illegal  = 1'b0;
`endif
      // Successor address for the instruction sitting in VALID; the adds
      // wrap modulo 2^16 by construction of the 16-bit result.
      if (branch_en)
         next_pc = branch_target;
      else if (instr_has_arg)
         next_pc = pc + 16'd2;
      else
         next_pc = pc + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         pc            <= RESET_PC;
         iram_addr     <= RESET_PC;
         instr_opcode  <= 16'd0;
         instr_operand <= 16'd0;
         instr_has_arg <= 1'b0;
         instr_pc      <= 16'd0;
      end else begin
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc        <= RESET_PC;
                  iram_addr <= RESET_PC;
                  state     <= S_OP_ADDR;
               end
            end
            // The IRAM registers the addressed word on this edge.
            S_OP_ADDR: state <= S_OP_DATA;
            S_OP_DATA: begin
               instr_opcode  <= iram_data;
               instr_pc      <= pc;
               instr_has_arg <= fetched_two_word;
               if (fetched_illegal) begin
                  state <= S_HALT;
               end else if (fetched_two_word) begin
                  iram_addr <= pc + 16'd1;
                  state     <= S_ARG_ADDR;
               end else begin
                  instr_operand <= 16'd0;
                  state         <= S_VALID;
               end
            end
            S_ARG_ADDR: state <= S_ARG_DATA;
            S_ARG_DATA: begin
               instr_operand <= iram_data;
               state         <= S_VALID;
            end
            S_VALID: begin
               // iram_addr only moves on acceptance, so a stall issues no
               // new IRAM access and a redirect never fetches the wrong path.
               if (instr_ready) begin
                  if (instr_opcode == OP_ENDOP) begin
                     state <= S_HALT;
                  end else begin
                     pc        <= next_pc;
                     iram_addr <= next_pc;
                     state     <= S_OP_ADDR;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef IFETCH_OPCHECK_EN
   logic illegal_flag;

   // Sticky until reset; a restart from HALT leaves it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         illegal_flag <= 1'b0;
      else if (state == S_OP_DATA && fetched_illegal)
         illegal_flag <= 1'b1;
   end

   assign instr_illegal = illegal_flag;
`else
   assign instr_illegal = 1'b0;
`endif

   assign instr_valid = (state == S_VALID);
   assign halted      = (state == S_HALT);
   assign busy        = (state != S_IDLE) && (state != S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch. Models the IRAM as a
//             64K-word array with one-cycle registered read, and predicts the
//             fetched instruction stream in program order from the memory
//             image, the handshake decisions and the branch requests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   localparam logic [15:0] RESET_PC = 16'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] iram_addr;
   logic [15:0] iram_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_opcode;
   logic [15:0] instr_operand;
   logic        instr_has_arg;
   logic [15:0] instr_pc;
   logic        branch_en;
   logic [15:0] branch_target;
   logic        busy;
   logic        halted;
   logic        instr_illegal;

   logic [15:0] mem [0:65535];
   logic [15:0] one_ops [0:15];
   logic [15:0] two_ops [0:7];
   logic [15:0] exp_pc;
   int          checks = 0;
   int          errors = 0;

   instr_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .iram_addr     (iram_addr),
      .iram_data     (iram_data),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_opcode  (instr_opcode),
      .instr_operand (instr_operand),
      .instr_has_arg (instr_has_arg),
      .instr_pc      (instr_pc),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .busy          (busy),
      .halted        (halted),
      .instr_illegal (instr_illegal)
   );

   always #5 clk = ~clk;

   // Synchronous-read IRAM
   always @(posedge clk) iram_data <= mem[iram_addr];

   function automatic bit two_word(input logic [15:0] op);
      return op inside {16'd5, 16'd7, 16'd9, 16'd14, 16'd19, 16'd24,
                        16'd46, 16'd48};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 65536; i++) begin
         if ($urandom_range(0, 1) == 1)
            mem[i] = two_ops[$urandom_range(0, 7)];
         else
            mem[i] = one_ops[$urandom_range(0, 15)];
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_iram_addr"}, iram_addr, RESET_PC);
      chk({tag, "_valid"},     16'(instr_valid), 16'd0);
      chk({tag, "_opcode"},    instr_opcode, 16'd0);
      chk({tag, "_operand"},   instr_operand, 16'd0);
      chk({tag, "_has_arg"},   16'(instr_has_arg), 16'd0);
      chk({tag, "_pc"},        instr_pc, 16'd0);
      chk({tag, "_busy"},      16'(busy), 16'd0);
      chk({tag, "_halted"},    16'(halted), 16'd0);
      chk({tag, "_illegal"},   16'(instr_illegal), 16'd0);
   endtask

   // Expected presentation of the instruction at exp_pc.
   task automatic check_fields(input string tag);
      logic [15:0] op;
      logic [15:0] a1;
      bit          two;
      op  = mem[exp_pc];
      two = two_word(op);
      a1  = exp_pc + 16'd1;
      chk({tag, "_valid"},     16'(instr_valid), 16'd1);
      chk({tag, "_opcode"},    instr_opcode, op);
      chk({tag, "_operand"},   instr_operand, two ? mem[a1] : 16'd0);
      chk({tag, "_has_arg"},   16'(instr_has_arg), 16'(two));
      chk({tag, "_pc"},        instr_pc, exp_pc);
      chk({tag, "_iram_addr"}, iram_addr, two ? a1 : exp_pc);
      chk({tag, "_busy"},      16'(busy), 16'd1);
   endtask

   task automatic start_run();
      @(negedge clk);
      start  = 1'b1;
      exp_pc = RESET_PC;
   endtask

   // One instruction: wait for it, check latency and fields, optionally
   // stall, then accept it with the given redirect request.
   task automatic step(input bit br, input logic [15:0] tgt, input int stall);
      int          n;
      bit          two;
      logic [15:0] op;
      logic [15:0] a1;
      op  = mem[exp_pc];
      two = two_word(op);
      a1  = exp_pc + 16'd1;
      n   = 0;
      do begin
         @(negedge clk);
         n++;
         // Noise on inputs that must be ignored outside a handshake/idle.
         instr_ready   = 1'b0;
         branch_en     = 1'($urandom_range(0, 1));
         branch_target = 16'($urandom);
         start         = 1'($urandom_range(0, 1));
         if (n == 1) begin
            chk("op_addr",    iram_addr, exp_pc);
            chk("run_busy",   16'(busy), 16'd1);
            chk("run_halted", 16'(halted), 16'd0);
         end
         if (n == 3 && two)
            chk("arg_addr", iram_addr, a1);
      end while (!instr_valid && n < 20);
      start = 1'b0;
      chk("latency", 16'(n), two ? 16'd5 : 16'd3);
      check_fields("valid");
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check_fields("stall");
      end
      instr_ready   = 1'b1;
      branch_en     = br;
      branch_target = tgt;
      if (op == 16'd51) begin
         @(negedge clk);
         instr_ready = 1'b0;
         branch_en   = 1'b0;
         chk("halt_halted", 16'(halted), 16'd1);
         chk("halt_busy",   16'(busy), 16'd0);
         chk("halt_valid",  16'(instr_valid), 16'd0);
         repeat (3) @(negedge clk);
         chk("halt_addr",   iram_addr, exp_pc);
         chk("halt_hold",   16'(halted), 16'd1);
      end else begin
         exp_pc = br ? tgt : exp_pc + (two ? 16'd2 : 16'd1);
      end
   endtask

   initial begin
      one_ops = '{16'd29, 16'd30, 16'd31, 16'd32, 16'd33, 16'd34, 16'd35,
                  16'd36, 16'd38, 16'd40, 16'd42, 16'd44, 16'd50, 16'd52,
                  16'd53, 16'd54};
      two_ops = '{16'd5, 16'd7, 16'd9, 16'd14, 16'd19, 16'd24, 16'd46,
                  16'd48};
      rst           = 1'b1;
      start         = 1'b0;
      instr_ready   = 1'b0;
      branch_en     = 1'b0;
      branch_target = 16'd0;
      exp_pc        = RESET_PC;

      // Directed program
      fill_random();
      mem[0]  = 16'd35;
      mem[1]  = 16'd7;   mem[2]  = 16'd6;
      mem[3]  = 16'd9;   mem[4]  = 16'd9;
      mem[5]  = 16'd46;  mem[6]  = 16'd67;
      mem[67] = 16'd48;  mem[68] = 16'd14;
      mem[14] = 16'd35;
      mem[69] = 16'd35;
      mem[98] = 16'd51;

      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 16'(busy), 16'd0);

      start_run();
      step(1'b0, 16'd0, 0);     // 35 at 0
      step(1'b0, 16'd0, 0);     // 7/6 at 1
      step(1'b0, 16'd0, 10);    // 9/9 at 3, stalled
      step(1'b1, 16'd67, 0);    // JUMP at 5 -> 67
      step(1'b1, 16'd14, 0);    // JPNZ at 67 taken -> 14
      step(1'b1, 16'd67, 0);    // 35 at 14 -> 67
      step(1'b0, 16'd0, 0);     // JPNZ at 67 not taken -> 69
      step(1'b1, 16'd98, 0);    // 35 at 69 -> 98
      step(1'b0, 16'd0, 0);     // ENDOP at 98

      // Randomized program, restart from HALT
      fill_random();
      start_run();
      for (int i = 0; i < 40; i++) begin
         logic [15:0] tgt;
         bit          br;
         br  = ($urandom_range(0, 3) == 0);
         tgt = 16'($urandom);
         if (i == 10 || i == 25) begin
            br  = 1'b1;
            tgt = 16'hFFFF;
         end else if (i == 18) begin
            br  = 1'b1;
            tgt = 16'hFFFE;
         end
         step(br, tgt, $urandom_range(0, 2));
      end
      mem[500] = 16'd51;
      step(1'b1, 16'd500, 0);
      step(1'b0, 16'd0, 0);

      // Reset in ARG_DATA discards the in-flight instruction
      mem[0] = 16'd7;
      mem[1] = 16'h1234;
      start_run();
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_opcode", instr_opcode, 16'd7);
      rst = 1'b1;
      #1;
      check_reset("midrst");
      @(negedge clk);
      rst = 1'b0;

      // Unknown opcode
      mem[0] = 16'h00FF;
      mem[1] = 16'd35;
`ifdef IFETCH_OPCHECK_EN
      start_run();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk("illegal_novalid", 16'(instr_valid), 16'd0);
      end
      chk("illegal_flag",   16'(instr_illegal), 16'd1);
      chk("illegal_halted", 16'(halted), 16'd1);
      chk("illegal_busy",   16'(busy), 16'd0);
      mem[0] = 16'd35;
      start_run();
      step(1'b0, 16'd0, 0);
      chk("illegal_sticky", 16'(instr_illegal), 16'd1);
`else
      start_run();
      step(1'b0, 16'd0, 0);
      step(1'b0, 16'd0, 0);
      chk("illegal_tied", 16'(instr_illegal), 16'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the instruction RAM. Drives the IRAM word address, absorbs its one-cycle registered read latency, and assembles one-word (opcode) and two-word (opcode + 16-bit operand) instructions. Presents each complete instruction to the control unit over a valid/ready handshake. Handles jump redirects and halts on ENDOP.

## Interface
- RESET_PC, 16'd0, fetch start address loaded on reset and on `start`
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin fetching at RESET_PC; honoured only in IDLE or HALT
- iram_addr  out  16  word address to IRAM; registered output
- iram_data  in  16  IRAM read data, valid one cycle after iram_addr is presented
- instr_valid  out  1  instruction fields valid; held until accepted
- instr_ready  in  1  control unit accepts the instruction
- instr_opcode  out  16  opcode word
- instr_operand  out  16  operand word; 0 for one-word instructions
- instr_has_arg  out  1  instruction is two words
- instr_pc  out  16  address of the opcode word
- branch_en  in  1  redirect request; sampled only on handshake
- branch_target  in  16  redirect address
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- instr_illegal  out  1  sticky illegal-opcode flag (see Configuration)

## Operation
- Two-word opcodes: LDAC=5, STAC=7, LDA=9, LDB=14, LDC=19, STC=24, JUMP=46, JPNZ=48. All others are one-word.
- ENDOP=51.
- Internal 16-bit pc. States: IDLE, OP_ADDR, OP_DATA, ARG_ADDR, ARG_DATA, VALID, HALT.
- IDLE: start=1 -> pc<=RESET_PC, go to OP_ADDR.
- OP_ADDR: iram_addr=pc. Go to OP_DATA.
- OP_DATA: capture iram_data into instr_opcode, with instr_pc=pc.
  - Two-word opcode -> go to ARG_ADDR.
  - Otherwise -> instr_operand<=0, go to VALID.
- ARG_ADDR: iram_addr=pc+1. Go to ARG_DATA.
- ARG_DATA: capture iram_data into instr_operand. Go to VALID.
- VALID: instr_valid=1 and all instr_* fields stable until instr_valid && instr_ready. On handshake:
  - Opcode ENDOP -> go to HALT.
  - Else if branch_en -> pc<=branch_target.
  - Else pc<=pc+1 (one-word) or pc<=pc+2 (two-word).
  - Then go to OP_ADDR.
- branch_en outside a VALID handshake is ignored.
- HALT: halted=1, no IRAM accesses. start=1 -> pc<=RESET_PC, go to OP_ADDR, halted clears the next cycle.
- pc arithmetic is modulo 2^16: 0xFFFF+1 -> 0x0000, 0xFFFF+2 -> 0x0001.
- No range check against IRAM depth; data from out-of-range addresses is passed through unchanged.
- start asserted in any state other than IDLE or HALT is ignored.

## Timing
- Reset (async, takes effect immediately):
  - State=IDLE, pc=RESET_PC, iram_addr=RESET_PC.
  - instr_valid=0, instr_opcode=0, instr_operand=0, instr_has_arg=0, instr_pc=0.
  - busy=0, halted=0, instr_illegal=0.
- A reset asserted mid-fetch or during VALID discards the in-flight instruction, with no handshake.
- iram_addr is updated on the edge that enters OP_ADDR/ARG_ADDR. The IRAM registers the word on the next edge, and OP_DATA/ARG_DATA sample it.
- Latency from OP_ADDR entry to instr_valid:
  - One-word instruction: 2 cycles.
  - Two-word instruction: 4 cycles.
- Back-to-back throughput: one one-word instruction per 3 cycles, one two-word instruction per 5 cycles, with instr_ready held high.
- instr_ready low stalls VALID indefinitely. No IRAM access occurs while stalled.
- A redirect takes effect on the first OP_ADDR after the handshake; there is no wrong-path fetch.

## Configuration
- IFETCH_OPCHECK_EN defined:
  - Legal opcodes: 5, 7, 9, 14, 19, 24, 29–36, 38, 40, 42, 44, 46, 48, 50–55, 59.
  - An illegal opcode in OP_DATA sets instr_illegal=1 and goes to HALT without asserting instr_valid.
  - instr_illegal stays set until reset. start from HALT restarts fetch without clearing it.
- IFETCH_OPCHECK_EN undefined:
  - Unknown opcodes are treated as one-word and presented normally.
  - instr_illegal is tied to 0.

## Test plan
- Reset, start pulse, IRAM[0]=35 (CLAC), ready=1 -> iram_addr=0; instr_valid 2 cycles after OP_ADDR with opcode=35, operand=0, has_arg=0, pc=0; next iram_addr=1.
- IRAM[1]=7, IRAM[2]=6 -> valid 4 cycles after OP_ADDR with opcode=7, operand=6, has_arg=1, pc=1; next fetch at address 3.
- Hold instr_ready=0 for 10 cycles on opcode 9/operand 9 -> instr_valid and all fields stable, iram_addr unchanged; ready=1 -> advance to pc+2.
- JPNZ (48) with operand 14 at pc 67, handshake with branch_en=1, branch_target=14 -> next opcode fetched from 14; same with branch_en=0 -> next fetch from 69.
- ENDOP (51) at pc 98 accepted -> halted=1, busy=0, no further iram_addr changes; start -> fetch restarts at RESET_PC.
- With IFETCH_OPCHECK_EN, opcode 0x00FF -> instr_illegal=1, halted=1, instr_valid never asserted; without it -> presented as one-word, next pc+1. Reset asserted during ARG_DATA -> all outputs at reset values within the same cycle.
